// File: rtl/instr_fetch.sv
// Single-issue instruction fetch: requests one word, holds it for downstream, then picks the next pc.
// Optional: define HALT_DETECT_EN to stop fetching for good after retiring opcode 6'b111111.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        stall,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, HALT} state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        imem_req_q, imem_req_d;
  logic        valid_q, valid_d;

  logic [31:0] seq_pc;
  logic [31:0] jump_target;
  logic [31:0] branch_offset;
  logic [31:0] branch_target;
  logic [31:0] retire_pc;
  logic        retire;
  logic        halt_hit;

  assign seq_pc        = pc_q + 32'd4;
  assign jump_target   = {seq_pc[31:28], instr_q[25:0], 2'b00};
  assign branch_offset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign branch_target = seq_pc + branch_offset;
  assign retire        = (state_q == HOLD) && !stall;

  // Jump wins over a taken branch; control inputs only matter on the retire cycle.
  always_comb begin
    retire_pc = seq_pc;
    if (jump) begin
      retire_pc = jump_target;
    end else if (branch && zero) begin
      retire_pc = branch_target;
    end
  end

`ifdef HALT_DETECT_EN
  logic halted_q, halted_d;

  assign halt_hit = retire && (instr_q[31:26] == 6'b111111);
  assign halted_d = halted_q || halt_hit;
  assign halted   = halted_q;
`else
  assign halt_hit = 1'b0;
  assign halted   = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    imem_req_d = imem_req_q;
    valid_d    = valid_q;
    case (state_q)
      IDLE: begin
        state_d    = REQ;
        imem_req_d = 1'b1;
      end
      REQ: begin
        if (imem_ack) begin
          instr_d    = imem_rdata;
          state_d    = HOLD;
          imem_req_d = 1'b0;
          valid_d    = 1'b1;
        end
      end
      HOLD: begin
        if (retire) begin
          pc_d    = retire_pc;
          valid_d = 1'b0;
          if (halt_hit) begin
            state_d = HALT;
          end else begin
            state_d    = REQ;
            imem_req_d = 1'b1;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d    = IDLE;
        imem_req_d = 1'b0;
        valid_d    = 1'b0;
      end
    endcase
  end

  // Reset aborts any outstanding access; the word it would have returned is never captured.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC_ALIGNED;
      instr_q    <= 32'h0000_0000;
      imem_req_q <= 1'b0;
      valid_q    <= 1'b0;
`ifdef HALT_DETECT_EN
      halted_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      imem_req_q <= imem_req_d;
      valid_q    <= valid_d;
`ifdef HALT_DETECT_EN
      halted_q   <= halted_d;
`endif
    end
  end

  assign imem_addr   = pc_q;
  assign imem_req    = imem_req_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign pc_plus4    = seq_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized scoreboard bench for instr_fetch: a memory/control driver predicts fetch addresses
// and held instructions from the pc rules, and a negedge monitor compares them against two DUTs.
module tb_instr_fetch;

  localparam logic [31:0] PC0 = 32'h0000_0000;
  localparam logic [31:0] PC1 = 32'h2000_0000;
`ifdef HALT_DETECT_EN
  localparam bit HALT_ON = 1'b1;
`else
  localparam bit HALT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_ack = 1'b0;
  logic        stall = 1'b0;
  logic        jump = 1'b0;
  logic        branch = 1'b0;
  logic        zero = 1'b0;

  logic [31:0] imem_addr, instr, pc, pc_plus4;
  logic [5:0]  opcode;
  logic        imem_req, instr_valid, halted;
  logic [31:0] imem_addr2, instr2, pc2, pc_plus4_2;
  logic [5:0]  opcode2;
  logic        imem_req2, instr_valid2, halted2;

  instr_fetch dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .stall(stall), .jump(jump),
    .branch(branch), .zero(zero), .instr(instr), .opcode(opcode),
    .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4), .halted(halted)
  );

  instr_fetch #(.RESET_PC(PC1)) dut2 (
    .clk(clk), .reset(reset), .imem_addr(imem_addr2), .imem_req(imem_req2),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .stall(stall), .jump(jump),
    .branch(branch), .zero(zero), .instr(instr2), .opcode(opcode2),
    .instr_valid(instr_valid2), .pc(pc2), .pc_plus4(pc_plus4_2), .halted(halted2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        jump;
    logic        branch;
    logic        zero;
    int          nstall;
    int          delay;
  } plan_t;

  typedef struct {
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic [31:0] a0;
    logic [31:0] a1;
  } addr_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];
  addr_t addr_q[$];

  int          total = 0;
  int          bad = 0;
  int          retired = 0;
  logic        exp_halted = 1'b0;
  logic        halt_pending = 1'b0;
  logic [31:0] mpc0 = PC0;
  logic [31:0] mpc1 = PC1;
  logic [31:0] last_instr = 32'h0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] ins, input logic j, input logic b, input logic z,
                                input int ns, input int dl);
    plan_t p;
    p.instr = ins; p.jump = j; p.branch = b; p.zero = z; p.nstall = ns; p.delay = dl;
    plan_q.push_back(p);
  endtask

  // Next pc written straight from the architectural rules with plain integer arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] cur_pc, input logic [31:0] ins,
                                             input logic j, input logic b, input logic z);
    logic [31:0] seq;
    int off;
    seq = cur_pc + 32'd4;
    if (j) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
    if (b && z) begin
      off = int'(ins & 32'h0000_FFFF);
      if (off > 32767) off = off - 65536;
      return seq + 32'(off * 4);
    end
    return seq;
  endfunction

  function automatic logic halts(input logic [31:0] ins);
    return HALT_ON && ((ins >> 26) == 32'h3F);
  endfunction

  function automatic plan_t rand_plan();
    plan_t p;
    logic [31:0] w;
    w = $urandom;
    if (halts(w)) w = w & 32'hFBFF_FFFF;
    p.instr  = w;
    p.jump   = ($urandom_range(0, 3) == 0);
    p.branch = 1'($urandom_range(0, 1));
    p.zero   = 1'($urandom_range(0, 1));
    p.nstall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    p.delay  = int'($urandom_range(0, 3));
    return p;
  endfunction

  // Driver: plays instruction memory and control unit, pushing predictions as it goes.
  initial begin : driver
    plan_t cur;
    int dly;
    int stall_left;
    logic req_active;
    logic [31:0] n0, n1;
    cur = rand_plan();
    dly = 0; stall_left = 0; req_active = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (reset) begin
        imem_ack = 1'b0; stall = 1'b0; jump = 1'b0; branch = 1'b0; zero = 1'b0;
        exp_q.delete();
        addr_q.delete();
        addr_q.push_back('{PC0, PC1});
        mpc0 = PC0; mpc1 = PC1;
        req_active = 1'b0; exp_halted = 1'b0; halt_pending = 1'b0;
        continue;
      end
      if (halt_pending) begin
        exp_halted = 1'b1;
        halt_pending = 1'b0;
      end
      imem_ack = 1'b0;
      branch = 1'($urandom_range(0, 1));
      zero = 1'($urandom_range(0, 1));
      if (imem_req) begin
        stall = 1'($urandom_range(0, 1));
        jump = 1'($urandom_range(0, 1));
        if (!req_active) begin
          req_active = 1'b1;
          if (plan_q.size() > 0) cur = plan_q.pop_front();
          else cur = rand_plan();
          dly = cur.delay;
          stall_left = cur.nstall;
        end
        if (dly == 0) begin
          imem_ack = 1'b1;
          imem_rdata = cur.instr;
          exp_q.push_back('{mpc0, mpc1, cur.instr});
          req_active = 1'b0;
        end else begin
          dly--;
          imem_rdata = $urandom;
        end
      end else if (instr_valid) begin
        if ($urandom_range(0, 3) == 0) begin
          imem_ack = 1'b1;
          imem_rdata = $urandom;
        end
        if (stall_left > 0) begin
          stall = 1'b1;
          jump = ~jump;
          stall_left--;
        end else begin
          stall = 1'b0;
          jump = cur.jump; branch = cur.branch; zero = cur.zero;
          retired++;
          n0 = model_next(mpc0, cur.instr, cur.jump, cur.branch, cur.zero);
          n1 = model_next(mpc1, cur.instr, cur.jump, cur.branch, cur.zero);
          if (halts(cur.instr)) begin
            halt_pending = 1'b1;
          end else begin
            addr_q.push_back('{n0, n1});
            mpc0 = n0;
            mpc1 = n1;
          end
        end
      end else begin
        stall = 1'($urandom_range(0, 1));
        jump = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) begin
          imem_ack = 1'b1;
          imem_rdata = $urandom;
        end
      end
    end
  end

  // Monitor: compares DUT outputs with the scoreboard queues away from the active edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        last_instr = 32'h0;
        continue;
      end
      check_output("halted", {31'b0, halted}, {31'b0, exp_halted});
      check_output("halted2", {31'b0, halted2}, {31'b0, exp_halted});
      if (exp_halted) begin
        check_output("halt req", {31'b0, imem_req}, 32'h0);
        check_output("halt valid", {31'b0, instr_valid}, 32'h0);
        continue;
      end
      if (imem_req) begin
        if (addr_q.size() == 0) begin
          check_output("unexpected req", {31'b0, imem_req}, 32'h0);
        end else begin
          check_output("imem_addr", imem_addr, addr_q[0].a0);
          check_output("imem_addr2", imem_addr2, addr_q[0].a1);
          check_output("req2", {31'b0, imem_req2}, 32'h1);
          check_output("valid in req", {31'b0, instr_valid}, 32'h0);
          check_output("instr held", instr, last_instr);
          if (imem_ack) void'(addr_q.pop_front());
        end
      end else if (instr_valid) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected valid", {31'b0, instr_valid}, 32'h0);
        end else begin
          e = exp_q[0];
          check_output("instr", instr, e.instr);
          check_output("opcode", {26'b0, opcode}, e.instr >> 26);
          check_output("pc", pc, e.pc0);
          check_output("pc_plus4", pc_plus4, e.pc0 + 32'd4);
          check_output("pc align", pc & 32'h3, 32'h0);
          check_output("valid2", {31'b0, instr_valid2}, 32'h1);
          check_output("instr2", instr2, e.instr);
          check_output("opcode2", {26'b0, opcode2}, e.instr >> 26);
          check_output("pc2", pc2, e.pc1);
          check_output("pc_plus4_2", pc_plus4_2, e.pc1 + 32'd4);
          if (!stall) begin
            last_instr = e.instr;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic assert_reset_async(input string tag);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check_output({tag, " pc"}, pc, PC0);
    check_output({tag, " pc_plus4"}, pc_plus4, PC0 + 32'd4);
    check_output({tag, " imem_addr"}, imem_addr, PC0);
    check_output({tag, " instr"}, instr, 32'h0);
    check_output({tag, " opcode"}, {26'b0, opcode}, 32'h0);
    check_output({tag, " valid"}, {31'b0, instr_valid}, 32'h0);
    check_output({tag, " req"}, {31'b0, imem_req}, 32'h0);
    check_output({tag, " halted"}, {31'b0, halted}, 32'h0);
    check_output({tag, " pc2"}, pc2, PC1);
    check_output({tag, " pc_plus4_2"}, pc_plus4_2, PC1 + 32'd4);
    plan_q.delete();
  endtask

  // A stray ack lands in the IDLE cycle right after release and must be ignored.
  task automatic release_reset();
    @(posedge clk);
    @(posedge clk); #3;
    reset = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic expect_fetch(input int after_retire, input logic [31:0] a0, input logic [31:0] a1,
                              input string name);
    int guard;
    guard = 0;
    while (retired < after_retire && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    while (!imem_req && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 400) begin
      check_output({name, " timeout"}, 32'h0, 32'h1);
    end else begin
      check_output(name, imem_addr, a0);
      check_output({name, " dut2"}, imem_addr2, a1);
    end
  endtask

  task automatic wait_retired(input int n);
    int guard;
    guard = 0;
    while (retired < n && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20000) check_output("retire timeout", 32'h0, 32'h1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int base;
    int guard;

    assert_reset_async("por");
    apply_stimulus(32'h8C02_0004, 1'b0, 1'b0, 1'b0, 0, 1);
    apply_stimulus(32'h0800_0004, 1'b1, 1'b0, 1'b0, 0, 0);
    apply_stimulus(32'h1000_FFFF, 1'b0, 1'b1, 1'b1, 0, 2);
    apply_stimulus(32'h1000_FFFF, 1'b0, 1'b1, 1'b0, 0, 0);
    apply_stimulus(32'h0800_0100, 1'b0, 1'b0, 1'b0, 5, 1);
    release_reset();
    base = retired;
    expect_fetch(base, 32'h0, PC1, "first fetch");
    guard = 0;
    while (!instr_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_output("lw opcode", {26'b0, opcode}, 32'h23);
    check_output("lw pc", pc, 32'h0);
    expect_fetch(base + 1, 32'h4, 32'h2000_0004, "after lw");
    expect_fetch(base + 2, 32'h10, 32'h2000_0010, "after jump");
    expect_fetch(base + 3, 32'h10, 32'h2000_0010, "branch taken");
    expect_fetch(base + 4, 32'h14, 32'h2000_0014, "branch not taken");
    expect_fetch(base + 5, 32'h18, 32'h2000_0018, "after stall");
    wait_retired(base + 300);

    assert_reset_async("rst2");
    apply_stimulus(32'h0800_0040, 1'b1, 1'b1, 1'b1, 0, 0);
    apply_stimulus(32'h0000_0000, 1'b0, 1'b0, 1'b0, 0, 4);
    release_reset();
    base = retired;
    expect_fetch(base, 32'h0, PC1, "rst2 first");
    expect_fetch(base + 1, 32'h100, 32'h2000_0100, "jump over branch");
    repeat (2) @(negedge clk);
    check_output("req before abort", {31'b0, imem_req}, 32'h1);
    check_output("addr before abort", imem_addr, 32'h100);
    assert_reset_async("mid-req");

    apply_stimulus(32'hFC00_0000, 1'b0, 1'b0, 1'b0, 0, 1);
    release_reset();
    base = retired;
    expect_fetch(base, 32'h0, PC1, "refetch after abort");
`ifdef HALT_DETECT_EN
    wait_retired(base + 1);
    repeat (3) @(negedge clk);
    check_output("halt entered", {31'b0, halted}, 32'h1);
    check_output("halt no req", {31'b0, imem_req}, 32'h0);
    repeat (20) @(negedge clk);
    check_output("halt sticky", {31'b0, halted}, 32'h1);
    check_output("halt still no req", {31'b0, imem_req}, 32'h0);
`else
    expect_fetch(base + 1, 32'h4, 32'h2000_0004, "0x3F retires normally");
    check_output("no halt", {31'b0, halted}, 32'h0);
    wait_retired(base + 20);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 Port clk, input, 1: SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1: SHALL be the reset, asynchronous and active-high.
REQ-004 Port imem_addr, output, 32: SHALL carry the instruction-memory word address, equal to pc.
REQ-005 Port imem_req, output, 1: SHALL request a fetch from instruction memory.
REQ-006 Port imem_rdata, input, 32: SHALL carry the fetched instruction word.
REQ-007 Port imem_ack, input, 1: SHALL mark imem_rdata valid for one cycle.
REQ-008 Port stall, input, 1: SHALL mean downstream holds the current instruction.
REQ-009 Port jump, input, 1: SHALL be the control-unit jump signal for the presented instruction.
REQ-010 Port branch, input, 1: SHALL be the control-unit branch signal for the presented instruction.
REQ-011 Port zero, input, 1: SHALL be the ALU zero flag for the presented instruction.
REQ-012 Port instr, output, 32: SHALL present the held instruction word.
REQ-013 Port opcode, output, 6: SHALL equal instr[31:26], feeding the control decoder.
REQ-014 Port instr_valid, output, 1: SHALL mark instr, opcode and pc valid.
REQ-015 Port pc, output, 32: SHALL give the address of the presented instruction.
REQ-016 Port pc_plus4, output, 32: SHALL equal pc+4, modulo 2^32.
REQ-017 Port halted, output, 1: SHALL indicate the halt state.

Function
REQ-018 FSM states SHALL be IDLE, REQ, HOLD and HALT.
REQ-019 IDLE SHALL last one cycle after reset release, then go to REQ; imem_ack in IDLE SHALL be ignored.
REQ-020 In REQ, imem_req SHALL be 1 and imem_addr stable until imem_ack is sampled high; instr SHALL then capture imem_rdata and the state SHALL go to HOLD.
REQ-021 imem_ack in a state other than REQ SHALL be ignored; an ack in the first REQ cycle SHALL be accepted.
REQ-022 In HOLD, instr_valid SHALL be 1 and imem_req 0; with stall=1 all state SHALL hold.
REQ-023 Retire SHALL occur in a HOLD cycle with stall=0; only then SHALL jump, branch and zero be sampled.
REQ-024 On retire, next pc SHALL be {pc_plus4[31:28], instr[25:0], 2'b00} if jump=1.
REQ-025 On retire with jump=0, next pc SHALL be pc_plus4 + (sign-extended instr[15:0] << 2) if branch=1 and zero=1; the add SHALL wrap modulo 2^32.
REQ-026 On retire otherwise, next pc SHALL be pc_plus4; jump SHALL take priority over branch.
REQ-027 After retire the state SHALL go to REQ with instr_valid=0 the next cycle; minimum cadence SHALL be 2 cycles per instruction.
REQ-028 pc[1:0] SHALL always be 2'b00.
REQ-029 instr and opcode SHALL hold their last value while instr_valid=0.

Reset
REQ-030 Reset assertion SHALL immediately force state IDLE, pc=RESET_PC, pc_plus4=RESET_PC+4, instr=0, opcode=0, instr_valid=0, imem_req=0 and halted=0, including mid-REQ or mid-HOLD.
REQ-031 An in-flight memory access aborted by reset SHALL be discarded; fetch SHALL restart from RESET_PC.

Configuration
REQ-032 With macro HALT_DETECT_EN defined, retiring an instruction with opcode 6'b111111 SHALL enter HALT, where imem_req=0, instr_valid=0 and halted=1 until reset.
REQ-033 With HALT_DETECT_EN undefined, opcode 6'b111111 SHALL be fetched and retired like any other instruction, HALT SHALL be unreachable, and halted SHALL be tied to 0.

Verification
REQ-034 Reset with RESET_PC=0, ack 1 cycle after req, rdata 32'h8C02_0004 -> imem_addr=0, then instr_valid=1, opcode=6'b100011, pc=0; no stall -> next imem_addr=4.
REQ-035 Instruction 32'h1000_FFFF at pc=0x10 with branch=1, zero=1 -> next pc=0x10; with zero=0 -> next pc=0x14.
REQ-036 Instruction 32'h0800_0040 at pc=0x2000_0000 with jump=1 and branch=1 -> next pc=0x2000_0100.
REQ-037 stall=1 for 5 HOLD cycles with jump toggling -> instr, pc and instr_valid remain constant, no request is issued, and jump is used only at the stall=0 cycle.
REQ-038 Ack delayed 4 cycles, and reset asserted mid-REQ -> imem_addr is stable while waiting, outputs reach reset values asynchronously, and refetch starts at RESET_PC.
REQ-039 HALT_DETECT_EN defined, rdata 32'hFC00_0000 retired -> halted=1 and imem_req=0 forever; HALT_DETECT_EN undefined -> fetch continues at pc+4.
